// File: rtl/jbi_mout_jid_pkg.sv
// Shared constants and drain-FSM encoding for the mout JID allocator.
// Used by jbi_mout_jid_ctl and jbi_mout_jid_rr_pick.
package jbi_mout_jid_pkg;

  localparam int NUM_JID = 16;
  localparam int JID_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } drain_state_e;

  // CSR limits above the pool size behave as the pool size.
  function automatic logic [CNT_W-1:0] clamp_limit(input logic [CNT_W-1:0] lim);
    return (lim > CNT_W'(NUM_JID)) ? CNT_W'(NUM_JID) : lim;
  endfunction

endpackage

// File: rtl/jbi_mout_jid_rr_pick.sv
// Rotate-priority encoder: first available JID at or above the round-robin
// pointer, wrapping from NUM_JID-1 back to 0.
module jbi_mout_jid_rr_pick
  import jbi_mout_jid_pkg::*;
(
  input  logic [NUM_JID-1:0] i_avail,
  input  logic [JID_W-1:0]   i_rr_ptr,
  output logic               o_found,
  output logic [JID_W-1:0]   o_jid
);

  logic [JID_W-1:0] w_idx;

  // Scan from farthest to nearest so the last hit is the closest one to rr_ptr.
  always_comb begin
    o_found = 1'b0;
    o_jid   = '0;
    w_idx   = '0;
    for (int i = NUM_JID - 1; i >= 0; i--) begin
      w_idx = i_rr_ptr + JID_W'(i);
      if (i_avail[w_idx]) begin
        o_found = 1'b1;
        o_jid   = w_idx;
      end
    end
  end

endmodule

// File: rtl/jbi_mout_jid_ctl.sv
// JBus transaction-ID allocator for outbound NC reads: round-robin grant,
// outstanding limit, release tracking and drain handshake.
// Optional ID-misuse checker compiled in with `define JBI_MOUT_JID_CHK_EN.
module jbi_mout_jid_ctl
  import jbi_mout_jid_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [JID_W-1:0] alloc_jid,
  input  logic             free_vld,
  input  logic [JID_W-1:0] free_jid,
  input  logic             nack_pop,
  input  logic [JID_W-1:0] nack_jid,
  input  logic [CNT_W-1:0] max_outstanding,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             pool_empty,
  output logic             pool_idle,
  output logic             jid_err
);

  drain_state_e       r_state;
  drain_state_e       w_state_nxt;
  logic [NUM_JID-1:0] r_avail;
  logic [NUM_JID-1:0] w_avail_nxt;
  logic [NUM_JID-1:0] w_rel_mask;
  logic [NUM_JID-1:0] w_gnt_mask;
  logic [JID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_busy_cnt;
  logic [CNT_W-1:0]   w_limit;
  logic               w_found;
  logic [JID_W-1:0]   w_pick_jid;
  logic               w_gate_run;
  logic               w_same_id;
  logic               w_free_eff;
  logic               w_nack_eff;
  logic [1:0]         w_rel_cnt;

  jbi_mout_jid_rr_pick u_rr_pick (
    .i_avail  (r_avail),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_jid    (w_pick_jid)
  );

  // drain_req closes the gate combinationally, even in the cycle it rises.
  assign w_limit    = clamp_limit(max_outstanding);
  assign w_gate_run = (r_state == RUN) & ~drain_req;
  assign alloc_gnt  = alloc_req & w_gate_run & w_found & (r_busy_cnt < w_limit);
  assign alloc_jid  = w_pick_jid;

  // Only releases of currently-busy IDs count; a doubled release counts once.
  assign w_same_id  = free_vld & nack_pop & (free_jid == nack_jid);
  assign w_free_eff = free_vld & ~r_avail[free_jid];
  assign w_nack_eff = nack_pop & ~r_avail[nack_jid] & ~w_same_id;
  assign w_rel_cnt  = {1'b0, w_free_eff} + {1'b0, w_nack_eff};

  always_comb begin
    w_rel_mask = '0;
    w_gnt_mask = '0;
    if (free_vld)  w_rel_mask[free_jid]  = 1'b1;
    if (nack_pop)  w_rel_mask[nack_jid]  = 1'b1;
    if (alloc_gnt) w_gnt_mask[alloc_jid] = 1'b1;
  end

  assign w_avail_nxt = (r_avail | w_rel_mask) & ~w_gnt_mask;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (drain_req) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)            w_state_nxt = RUN;
        else if (r_busy_cnt == '0) w_state_nxt = DRAINED;
      end
      DRAINED: if (!drain_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_avail    <= '1;
      r_rr_ptr   <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_avail    <= w_avail_nxt;
      r_busy_cnt <= r_busy_cnt + CNT_W'(alloc_gnt) - CNT_W'(w_rel_cnt);
      if (alloc_gnt) r_rr_ptr <= alloc_jid + JID_W'(1);
    end
  end

  assign drain_done = (r_state == DRAINED);
  assign busy_cnt   = r_busy_cnt;
  assign pool_empty = (r_busy_cnt == CNT_W'(NUM_JID));
  assign pool_idle  = (r_busy_cnt == '0);

`ifdef JBI_MOUT_JID_CHK_EN
  logic r_jid_err;
  logic w_err;

  assign w_err = (free_vld & r_avail[free_jid]) |
                 (nack_pop & r_avail[nack_jid]) |
                 w_same_id |
                 (alloc_gnt & (r_busy_cnt == CNT_W'(NUM_JID)));

  always_ff @(posedge clk) begin
    if (rst) r_jid_err <= 1'b0;
    else     r_jid_err <= w_err;
  end

  assign jid_err = r_jid_err;
`else
  assign jid_err = 1'b0;
`endif

endmodule

// File: tb/tb_jbi_mout_jid_ctl.sv
// Bench for jbi_mout_jid_ctl: directed table, hand sequences and random
// traffic checked against a pool-level reference model.
module tb_jbi_mout_jid_ctl;

  logic       clk = 1'b0;
  logic       rst, alloc_req, free_vld, nack_pop, drain_req;
  logic [3:0] free_jid, nack_jid;
  logic [4:0] max_outstanding;
  logic       alloc_gnt, drain_done, pool_empty, pool_idle, jid_err;
  logic [3:0] alloc_jid;
  logic [4:0] busy_cnt;

  jbi_mout_jid_ctl dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_jid(alloc_jid), .free_vld(free_vld), .free_jid(free_jid),
    .nack_pop(nack_pop), .nack_jid(nack_jid), .max_outstanding(max_outstanding),
    .drain_req(drain_req), .drain_done(drain_done), .busy_cnt(busy_cnt),
    .pool_empty(pool_empty), .pool_idle(pool_idle), .jid_err(jid_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model: which IDs are held, where the next search starts,
  // and the drain mode (0 running, 1 draining, 2 drained).
  bit m_held[16];
  int m_next;
  int m_mode;
  bit m_err;

  // Values sampled from the DUT at the last negedge.
  logic       s_gnt, s_done, s_empty, s_idle, s_err;
  logic [3:0] s_jid;
  logic [4:0] s_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc_no, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 16; k++) c += int'(m_held[k]);
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 16; k++) m_held[k] = 1'b0;
    m_next = 0;
    m_mode = 0;
    m_err  = 1'b0;
  endtask

  task automatic cyc(input logic r, input logic rq, input logic fv, input int fj,
                     input logic np, input int nj, input int mx, input logic dr);
    int  cnt, lim, pick;
    bit  e_gnt, e_err;
    rst = r; alloc_req = rq; free_vld = fv; free_jid = 4'(fj);
    nack_pop = np; nack_jid = 4'(nj); max_outstanding = 5'(mx); drain_req = dr;
    @(negedge clk);
    s_gnt = alloc_gnt; s_jid = alloc_jid; s_busy = busy_cnt; s_done = drain_done;
    s_empty = pool_empty; s_idle = pool_idle; s_err = jid_err;
    cnt  = m_count();
    lim  = (mx > 16) ? 16 : mx;
    pick = -1;
    for (int k = 15; k >= 0; k--) if (!m_held[(m_next + k) % 16]) pick = (m_next + k) % 16;
    e_gnt = rq && (m_mode == 0) && !dr && (pick >= 0) && (cnt < lim);
    chk("alloc_gnt", s_gnt, e_gnt);
    if (e_gnt) chk("alloc_jid", s_jid, pick);
    chk("busy_cnt", s_busy, cnt);
    chk("pool_empty", s_empty, cnt == 16);
    chk("pool_idle", s_idle, cnt == 0);
    chk("drain_done", s_done, m_mode == 2);
    chk("jid_err", s_err, m_err);
`ifdef JBI_MOUT_JID_CHK_EN
    e_err = (fv && !m_held[fj]) || (np && !m_held[nj]) || (fv && np && fj == nj) ||
            (e_gnt && cnt == 16);
`else
    e_err = 1'b0;
`endif
    @(posedge clk);
    cyc_no++;
    if (r) begin
      m_reset();
    end else begin
      m_err = e_err;
      if (fv) m_held[fj] = 1'b0;
      if (np) m_held[nj] = 1'b0;
      if (e_gnt) begin
        m_held[pick] = 1'b1;
        m_next = (pick + 1) % 16;
      end
      case (m_mode)
        0: if (dr) m_mode = 1;
        1: if (!dr) m_mode = 0; else if (cnt == 0) m_mode = 2;
        default: if (!dr) m_mode = 0;
      endcase
    end
    #1;
  endtask

  typedef struct {
    logic       r, rq, fv;
    logic [3:0] fj;
    logic       np;
    logic [3:0] nj;
    logic [4:0] mx;
    logic       dr;
    logic       e_gnt;
    logic [3:0] e_jid;
    logic [4:0] e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t v(logic r, logic rq, logic fv, int fj, logic np, int nj,
                             int mx, logic dr, logic eg, int ej, int eb, logic ed);
    vec_t t;
    t.r = r; t.rq = rq; t.fv = fv; t.fj = 4'(fj); t.np = np; t.nj = 4'(nj);
    t.mx = 5'(mx); t.dr = dr; t.e_gnt = eg; t.e_jid = 4'(ej); t.e_busy = 5'(eb);
    t.e_done = ed;
    return t;
  endfunction

  initial begin
    //            r  rq fv fj np nj mx dr  gnt jid busy done
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 3, 0,  0, 0, 16, 0);
    tbl[1]  = v(0, 1, 0, 0, 0, 0, 3, 0,  1, 0,  0, 0);
    tbl[2]  = v(0, 1, 0, 0, 0, 0, 3, 0,  1, 1,  1, 0);
    tbl[3]  = v(0, 1, 0, 0, 0, 0, 3, 0,  1, 2,  2, 0);
    tbl[4]  = v(0, 1, 0, 0, 0, 0, 3, 0,  0, 0,  3, 0);
    tbl[5]  = v(0, 1, 0, 0, 1, 1, 3, 0,  0, 0,  3, 0);
    tbl[6]  = v(0, 1, 0, 0, 0, 0, 3, 0,  1, 3,  2, 0);
    tbl[7]  = v(0, 1, 0, 0, 0, 0, 16, 0, 1, 4,  3, 0);
    tbl[8]  = v(0, 1, 0, 0, 0, 0, 16, 1, 0, 0,  4, 0);
    tbl[9]  = v(0, 1, 1, 0, 0, 0, 16, 1, 0, 0,  4, 0);
    tbl[10] = v(0, 0, 1, 2, 0, 0, 16, 1, 0, 0,  3, 0);
    tbl[11] = v(0, 0, 1, 3, 1, 3, 16, 1, 0, 0,  2, 0);
    tbl[12] = v(0, 0, 1, 4, 0, 0, 16, 1, 0, 0,  1, 0);
    tbl[13] = v(0, 1, 0, 0, 0, 0, 16, 1, 0, 0,  0, 0);
    tbl[14] = v(0, 1, 0, 0, 0, 0, 16, 1, 0, 0,  0, 1);
    tbl[15] = v(0, 1, 0, 0, 0, 0, 16, 0, 0, 0,  0, 1);
    tbl[16] = v(0, 1, 0, 0, 0, 0, 16, 0, 1, 5,  0, 0);
    tbl[17] = v(0, 0, 1, 9, 0, 0, 16, 0, 0, 0,  1, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 16, 0, 0, 0,  1, 0);

    // Initial reset, then model and DUT start aligned.
    rst = 1'b1; alloc_req = 1'b0; free_vld = 1'b0; free_jid = '0; nack_pop = 1'b0;
    nack_jid = '0; max_outstanding = 5'd16; drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Reset values.
    cyc(0, 0, 0, 0, 0, 0, 16, 0);
    chk("reset_idle", s_idle, 1'b1);
    chk("reset_busy", s_busy, 0);

    // Fill the pool: 0..15 in order, 17th request refused.
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 16, 0);
      if (i < 16) begin
        chk("fill_gnt", s_gnt, 1'b1);
        chk("fill_jid", s_jid, i);
      end else begin
        chk("full_gnt", s_gnt, 1'b0);
        chk("full_empty", s_empty, 1'b1);
        chk("full_busy", s_busy, 16);
      end
    end

    // Released ID is not grantable in its release cycle, only the next one.
    cyc(0, 1, 1, 5, 0, 0, 16, 0);
    chk("rel_same_cyc_gnt", s_gnt, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 16, 0);
    chk("regrant_gnt", s_gnt, 1'b1);
    chk("regrant_jid", s_jid, 5);
    chk("regrant_busy", s_busy, 15);

    // Limit of 3, round-robin after nack, drain handshake, spurious release.
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].rq, tbl[i].fv, tbl[i].fj, tbl[i].np, tbl[i].nj,
          tbl[i].mx, tbl[i].dr);
      chk($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].e_gnt);
      if (tbl[i].e_gnt) chk($sformatf("tbl%0d_jid", i), s_jid, tbl[i].e_jid);
      chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), s_done, tbl[i].e_done);
    end

    // Reset with 10 outstanding during a drain; release in the reset cycle ignored.
    repeat (9) cyc(0, 1, 0, 0, 0, 0, 16, 0);
    cyc(0, 0, 0, 0, 0, 0, 16, 1);
    chk("pre_rst_busy", s_busy, 10);
    cyc(1, 0, 1, 5, 0, 0, 16, 1);
    cyc(0, 1, 0, 0, 0, 0, 16, 0);
    chk("post_rst_busy", s_busy, 0);
    chk("post_rst_idle", s_idle, 1'b1);
    chk("post_rst_done", s_done, 1'b0);
    chk("post_rst_gnt", s_gnt, 1'b1);
    chk("post_rst_jid", s_jid, 0);

    // Random traffic against the model.
    begin
      logic dr_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        int mx;
        logic rr;
        if ($urandom_range(0, 39) == 0) dr_r = ~dr_r;
        mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 16;
        rr = ($urandom_range(0, 299) == 0);
        cyc(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
            int'($urandom_range(0, 15)), $urandom_range(0, 9) < 2,
            int'($urandom_range(0, 15)), mx, dr_r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
